// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths, ALU operation encodings and stage types.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int CTRL_W     = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_2r1w.sv
// ============================================================================
// Module      : reg_file_2r1w
// Description : 32x32 register file, two combinational reads with same-cycle
//               write bypass, one synchronous write, hardwired zero register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_file_2r1w
  import alu_pkg::*;
#(
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]     mem [NUM_REGS];
  logic [REG_ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0]     rd_data [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_IDX)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Zero-register check comes first, so a write aimed at it never bypasses.
  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    assign rd_data[p] = (rd_addr[p] == ZERO_IDX)                ? '0      :
                        (wr_en && (wr_addr == rd_addr[p]))      ? wr_data :
                                                                  mem[rd_addr[p]];
  end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module      : alu_operand_stage
// Description : Operand fetch/issue stage feeding the ALU through a one-entry
//               registered output slot with valid/ready handshake.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic                  imm_en,
  input  logic [DATA_W-1:0]     imm,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     src1,
  output logic [DATA_W-1:0]     src2,
  output logic [CTRL_W-1:0]     ALU_control
);

  slot_state_t       state;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              accept;

  reg_file_2r1w #(
    .ZERO_REG (ZERO_REG)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rs_addr),
    .rd_data_a (rs_data),
    .rd_addr_b (rt_addr),
    .rd_data_b (rt_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  assign out_valid = (state == SLOT_FULL);
  assign in_ready  = (state == SLOT_EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;

  // Operands are captured on accept only, so a held op is an immutable snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SLOT_EMPTY;
      src1        <= '0;
      src2        <= '0;
      ALU_control <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (accept) state <= SLOT_FULL;
        SLOT_FULL:  if (!accept && out_ready) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      if (accept) begin
        src1        <= rs_data;
        src2        <= imm_en ? imm : rt_data;
        ALU_control <= ctrl_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed self-checking bench for alu_operand_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [3:0]  ctrl_in;
  logic        imm_en;
  logic [31:0] imm;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALU_control;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.ZERO_REG(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .ctrl_in     (ctrl_in),
    .imm_en      (imm_en),
    .imm         (imm),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [3:0] ec);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_src1"}, src1, e1);
    chk({tag, "_src2"}, src2, e2);
    chk({tag, "_ctrl"}, {28'd0, ALU_control}, {28'd0, ec});
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] c,
                       input logic ie, input logic [31:0] im);
    in_valid = 1'b1;
    rs_addr  = rs;
    rt_addr  = rt;
    ctrl_in  = c;
    imm_en   = ie;
    imm      = im;
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rs_addr = '0; rt_addr = '0; ctrl_in = '0;
    imm_en = 1'b0; imm = '0; out_ready = 1'b1;
    wr(1'b0, 5'd0, 32'd0);
    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_src1", src1, 32'd0);
    chk("rst_src2", src2, 32'd0);
    chk("rst_ctrl", {28'd0, ALU_control}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Write then read
    wr(1'b1, 5'd5, 32'h0000_00FF);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    issue(5'd5, 5'd0, ALU_ADD, 1'b0, 32'd0);
    tick();
    chk_out("wr_rd", 32'h0000_00FF, 32'd0, ALU_ADD);

    // Same-cycle bypass on both ports
    wr(1'b1, 5'd3, 32'hDEAD_BEEF);
    issue(5'd3, 5'd3, ALU_AND, 1'b0, 32'd0);
    tick();
    chk_out("bypass", 32'hDEAD_BEEF, 32'hDEAD_BEEF, ALU_AND);

    // Zero register: discarded write, and no bypass when writing r0 again
    in_valid = 1'b0;
    wr(1'b1, 5'd0, 32'h1234_5678);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_hold_src1", src1, 32'hDEAD_BEEF);
    issue(5'd0, 5'd0, ALU_OR, 1'b0, 32'd0);
    tick();
    chk_out("zero_reg", 32'd0, 32'd0, ALU_OR);

    // Immediate select
    in_valid = 1'b0;
    wr(1'b1, 5'd4, 32'h0000_0010);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    issue(5'd4, 5'd1, ALU_SUB, 1'b1, 32'hFFFF_FFF0);
    tick();
    chk_out("imm", 32'h0000_0010, 32'hFFFF_FFF0, ALU_SUB);

    // Backpressure: FULL slot held, rs register rewritten underneath it
    out_ready = 1'b0;
    issue(5'd5, 5'd3, ALU_OR, 1'b0, 32'd0);
    wr(1'b1, 5'd4, 32'hAAAA_AAAA);
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      wr(1'b0, 5'd0, 32'd0);
      chk_out("stall", 32'h0000_0010, 32'hFFFF_FFF0, ALU_SUB);
      chk("stall_in_ready_n", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("release", 32'h0000_00FF, 32'hDEAD_BEEF, ALU_OR);

    // Streaming: preload r10..r17, then 8 back-to-back ops
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(1'b1, 5'(10 + i), 32'h1000_0000 + 32'(i));
      tick();
    end
    wr(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      issue(5'(10 + i), 5'd0, 4'(i), 1'b1, 32'(i) * 32'h0101_0101);
      #1;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("stream", 32'h1000_0000 + 32'(i), 32'(i) * 32'h0101_0101, 4'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", {31'd0, out_valid}, 32'd0);

    // Reset asserted mid-stall
    issue(5'd5, 5'd4, ALU_NOR, 1'b0, 32'd0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_out("pre_rst", 32'h0000_00FF, 32'hAAAA_AAAA, ALU_NOR);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_src1", src1, 32'd0);
    chk("mid_rst_src2", src2, 32'd0);
    chk("mid_rst_ctrl", {28'd0, ALU_control}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    issue(5'd7, 5'd9, ALU_SLT, 1'b0, 32'd0);
    tick();
    chk_out("post_rst", 32'd0, 32'd0, ALU_SLT);
    issue(5'd5, 5'd4, ALU_ADD, 1'b0, 32'd0);
    tick();
    chk_out("post_rst_cleared", 32'd0, 32'd0, ALU_ADD);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch and issue stage directly upstream of the 32-bit ALU. Holds the 32×32 general-purpose register file, selects register or immediate for the second operand, and presents `src1`, `src2` and `ALU_control` to the ALU from a registered output slot with a valid/ready handshake. Write-back from later stages enters through a single write port with same-cycle bypass.

## Interface
- `ZERO_REG`, default 0: index of the hardwired-zero register.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage can accept this cycle.
- `rs_addr`  in  5  source-1 register index.
- `rt_addr`  in  5  source-2 register index.
- `ctrl_in`  in  4  ALU operation code, passed through to `ALU_control`.
- `imm_en`  in  1  1 = `src2` takes `imm`; 0 = `src2` takes `reg[rt_addr]`.
- `imm`  in  32  pre-extended immediate.
- `wr_en`  in  1  write-back strobe.
- `wr_addr`  in  5  write-back register index.
- `wr_data`  in  32  write-back data.
- `out_valid`  out  1  operands valid to the ALU.
- `out_ready`  in  1  ALU side consumes this cycle.
- `src1`  out  32  ALU operand 1.
- `src2`  out  32  ALU operand 2.
- `ALU_control`  out  4  ALU operation code.

## Operation
- Register file: 32 entries × 32 bits, two combinational read ports, one synchronous write port.
- Writes with `wr_addr == ZERO_REG` are discarded. Reads of `ZERO_REG` return 0.
- Bypass: if `wr_en` is high, `wr_addr == rs_addr` (or `rt_addr`), and the index is nonzero, the read returns `wr_data` in the same cycle.
- The output slot has two states.
  - EMPTY → FULL on accept.
  - FULL → FULL on accept together with `out_ready`.
  - FULL → EMPTY on `out_ready` with no accept.
  - FULL stays FULL while `out_ready` is 0.
- `in_ready = !out_valid || out_ready`. This is combinational; no bubble is needed for back-to-back issue.
- Accept is `in_valid && in_ready`. On accept, the following load on the next edge, all from the same cycle:
  - `src1` ← bypassed `reg[rs_addr]`.
  - `src2` ← `imm_en ? imm : bypassed reg[rt_addr]`.
  - `ALU_control` ← `ctrl_in`.
- Held operands are snapshots. A later write to `rs` or `rt` does not change a FULL slot's contents.
- `wr_en` is independent of the handshake. Writes proceed whether or not anything is accepted or stalled.

## Timing
- Latency is 1 cycle: accept at edge N, `out_valid`/`src1`/`src2`/`ALU_control` valid after edge N.
- Throughput is 1 op/cycle while `out_ready` stays high.
- A write at edge N is visible through the array from cycle N+1. It is visible via bypass in cycle N itself.
- On reset assertion, immediately and asynchronously:
  - all 32 registers = 0;
  - `out_valid` = 0;
  - `src1` = `src2` = 0;
  - `ALU_control` = 4'b0000.
- `in_ready` = 1 while in reset and after reset release.
- Reset asserted mid-stall discards the held op. Nothing is replayed.
- While `out_valid` is 0, `src1`/`src2`/`ALU_control` hold their last values. The ALU must qualify its use with `out_valid`.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_control` encodings: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, SLT 4'b0111, NOR 4'b1100;
  - `REG_ADDR_W` = 5, `DATA_W` = 32, `NUM_REGS` = 32.
- Sub-module `reg_file_2r1w` contains the array, the zero-register rule and the bypass.
- The top level contains the output slot and the handshake.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → `out_valid`=0, `src1`=`src2`=0, `ALU_control`=0. Then issue `rs`=7, `rt`=9 → both operands 0.
- Write then read: write r5=32'h0000_00FF, next cycle issue `rs`=5, `rt`=0, `ctrl`=ADD → `src1`=32'h0000_00FF, `src2`=0, `ALU_control`=4'b0010, one cycle later.
- Same-cycle bypass and zero register:
  - write r3=32'hDEAD_BEEF in the same cycle as issue `rs`=3, `rt`=3 → both operands 32'hDEAD_BEEF;
  - write r0=32'h1234_5678, then issue `rs`=0 → `src1`=0.
- Immediate select: r4=32'h0000_0010, issue `rs`=4, `imm_en`=1, `imm`=32'hFFFF_FFF0, `ctrl`=SUB → `src1`=32'h10, `src2`=32'hFFFF_FFF0, `ALU_control`=4'b0110.
- Backpressure:
  - hold `out_ready`=0 for 3 cycles with a FULL slot → `in_ready`=0 and the outputs stay stable;
  - meanwhile write the slot's `rs` register → the held `src1` is unchanged;
  - raise `out_ready` → the next op is accepted in that same cycle.
- Streaming: 8 consecutive ops with `out_ready`=1 → 8 consecutive `out_valid` cycles, in order, with no bubbles.
